// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver with 2-of-3 majority voting; parity support is compiled in by UART_RX_PARITY_EN
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  rx_busy
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;
  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d, p_q, p_d, half;
  logic [BW-1:0]         bit_q, bit_d;
  logic [2:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, pdata_q, pdata_d;
  logic                  dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
  logic                  bit_end, vote, mis;
  assign half    = p_q >> 1;
  assign bit_end = cnt_q == p_q - 6'd1;
  assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
`ifdef UART_RX_PARITY_EN
  logic pen_q, pen_d, ptyp_q, ptyp_d, pmis_q, pmis_d;
  assign mis = pmis_q;
  // Per-frame parity mode and the parity check result carried into STOP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pen_q  <= 1'b0;
      ptyp_q <= 1'b0;
      pmis_q <= 1'b0;
    end else begin
      pen_q  <= pen_d;
      ptyp_q <= ptyp_d;
      pmis_q <= pmis_d;
    end
  end
`else
  logic unused_par;
  assign unused_par = par_en ^ par_typ;
  assign mis = 1'b0;
`endif
  // FSM state, bit timing and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= 6'd8;
      bit_q   <= '0;
      smp_q   <= '0;
      sh_q    <= '0;
      pdata_q <= '0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      pdata_q <= pdata_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end
  // Next state: the three mid-bit samples are voted at the last edge of each bit period
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || bit_end) ? 6'd0 : cnt_q + 6'd1;
    p_d     = p_q;
    bit_d   = bit_q;
    smp_d   = {cnt_q == half + 6'd1 ? rx_in : smp_q[2],
               cnt_q == half        ? rx_in : smp_q[1],
               cnt_q == half - 6'd1 ? rx_in : smp_q[0]};
    sh_d    = sh_q;
    pdata_d = pdata_q;
    dv_d    = 1'b0;
    perr_d  = perr_q;
    serr_d  = serr_q;
`ifdef UART_RX_PARITY_EN
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    pmis_d  = pmis_q;
`endif
    case (state_q)
      IDLE: if (!rx_in) begin
        state_d = START;
        p_d     = (prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd8;
        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
        pen_d   = par_en;
        ptyp_d  = par_typ;
        pmis_d  = 1'b0;
`endif
      end
      START: if (bit_end) state_d = vote ? IDLE : DATA;
      DATA: if (bit_end) begin
        sh_d  = {vote, sh_q[DATA_WIDTH-1:1]};
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(DATA_WIDTH - 1))
`ifdef UART_RX_PARITY_EN
          state_d = pen_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) begin
        pmis_d  = (^sh_q ^ ptyp_q) != vote;
        state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        serr_d  = !vote;
        perr_d  = mis;
        state_d = IDLE;
        if (vote && !mis) begin
          pdata_d = sh_q;
          dv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign p_data     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;
  assign rx_busy    = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed vector table, hand-written corner sequences and randomized frames against a frame-level model
module tb_uart_rx_deserializer;
  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic          clk = 1'b0, rst = 1'b0, rx_in = 1'b1, par_en = 1'b0, par_typ = 1'b0;
  logic [5:0]    prescale = 6'd8;
  logic [DW-1:0] p_data;
  logic          data_valid, par_err, stp_err, rx_busy;
  int            vectors = 0, miscompares = 0;
  int            cyc = 0, dv_cnt = 0, dv_cyc = -1;
  logic [DW-1:0] m_pdata = '0;
  bit            m_perr = 1'b0, m_serr = 1'b0;

  typedef struct {
    logic [5:0]    p;
    bit            pe, pt;
    logic [DW-1:0] d;
    bit            bad, stop, noise;
    bit            dv;
    logic [DW-1:0] pd;
    bit            perr, serr;
  } vec_t;
  vec_t tbl[5];

  uart_rx_deserializer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (data_valid) begin
    dv_cnt <= dv_cnt + 1;
    dv_cyc <= cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_frame(input logic [5:0] p, input bit pe, input bit pt, input logic [DW-1:0] d,
                             input bit bad, input bit stop, input bit noise, input bit scramble,
                             output int k, output int n, output int pp);
    bit bits[$];
    pp = (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    bits = {1'b0};
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (PAR && pe) bits.push_back(^d ^ pt ^ bad);
    bits.push_back(stop);
    n = bits.size();
    @(posedge clk); #1;
    prescale = p;
    par_en   = pe;
    par_typ  = pt;
    k = cyc;
    for (int b = 0; b < n; b++)
      for (int j = 0; j < pp; j++) begin
        rx_in = (noise && b >= 1 && b <= DW && j == pp / 2 + 1) ? ~bits[b] : bits[b];
        if (scramble && b == 1 && j == 0) begin
          prescale = 6'($urandom);
          par_en   = 1'($urandom);
          par_typ  = 1'($urandom);
        end
        @(posedge clk); #1;
      end
    rx_in = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [5:0] p, input bit pe, input bit pt,
                           input logic [DW-1:0] d, input bit bad, input bit stop, input bit noise,
                           input bit scramble, input bit e_dv, input logic [DW-1:0] e_pd,
                           input bit e_pe, input bit e_se);
    int k, n, pp, dv0;
    dv0 = dv_cnt;
    drive_frame(p, pe, pt, d, bad, stop, noise, scramble, k, n, pp);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " dv_pulses"}, 32'(dv_cnt - dv0), 32'(e_dv));
    if (e_dv) chk({tag, " latency"}, 32'(dv_cyc - k), 32'(1 + n * pp));
    chk({tag, " p_data"}, 32'(p_data), 32'(e_pd));
    chk({tag, " par_err"}, 32'(par_err), 32'(e_pe));
    chk({tag, " stp_err"}, 32'(stp_err), 32'(e_se));
    chk({tag, " rx_busy"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int dv0;
    logic [5:0] p;
    bit pe, pt, bad, stop, noise, e_pe, e_se, e_dv;
    logic [DW-1:0] d;
    tbl[0] = '{6'd8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{6'd16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, !PAR, PAR ? 8'hA5 : 8'h3C, PAR, 1'b0};
    tbl[2] = '{6'd32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, PAR ? 8'hA5 : 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{6'd32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{6'd16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset p_data", 32'(p_data), 32'd0);
    chk("reset data_valid", 32'(data_valid), 32'd0);
    chk("reset par_err", 32'(par_err), 32'd0);
    chk("reset stp_err", 32'(stp_err), 32'd0);
    chk("reset rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle rx_busy", 32'(rx_busy), 32'd0);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].p, tbl[i].pe, tbl[i].pt, tbl[i].d, tbl[i].bad,
                tbl[i].stop, tbl[i].noise, 1'b0, tbl[i].dv, tbl[i].pd, tbl[i].perr, tbl[i].serr);
    m_pdata = 8'h5A;

    prescale = 6'd8;
    dv0 = dv_cnt;
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    chk("glitch busy_in_start", 32'(rx_busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("glitch busy_last_start", 32'(rx_busy), 32'd1);
    @(posedge clk); #1;
    chk("glitch back_to_idle", 32'(rx_busy), 32'd0);
    chk("glitch dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    chk("glitch p_data", 32'(p_data), 32'(m_pdata));
    chk("glitch par_err", 32'(par_err), 32'd0);
    chk("glitch stp_err", 32'(stp_err), 32'd0);

    dv0 = dv_cnt;
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rstmid busy_in_data", 32'(rx_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid p_data", 32'(p_data), 32'd0);
    chk("rstmid data_valid", 32'(data_valid), 32'd0);
    chk("rstmid par_err", 32'(par_err), 32'd0);
    chk("rstmid stp_err", 32'(stp_err), 32'd0);
    chk("rstmid rx_busy", 32'(rx_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rstmid no_dv", 32'(dv_cnt - dv0), 32'd0);
    run_frame("after_rst", 6'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    m_pdata = 8'h81;

    for (int r = 0; r < 25; r++) begin
      case ($urandom_range(0, 3))
        0: p = 6'd8;
        1: p = 6'd16;
        2: p = 6'd32;
        default: p = 6'($urandom);
      endcase
      pe    = 1'($urandom);
      pt    = 1'($urandom);
      d     = DW'($urandom);
      bad   = $urandom_range(0, 4) == 0;
      stop  = $urandom_range(0, 4) != 0;
      noise = 1'($urandom);
      e_pe  = PAR && pe && bad;
      e_se  = !stop;
      e_dv  = !e_pe && !e_se;
      if (e_dv) m_pdata = d;
      run_frame($sformatf("rand%0d", r), p, pe, pt, d, bad, stop, noise, 1'b1, e_dv, m_pdata, e_pe, e_se);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
